// File: rtl/dmem_pkg.sv
// Shared constants, arbiter state encoding and port indices for the dmem arbiter.
package dmem_pkg;

  localparam int AW = 12;
  localparam int DW = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_LOCK1 = 1'b1
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and dmem-side bus of the arbiter; the slave modport is the arbiter's view.
interface dmem_arbiter_if #(
  parameter int AW = dmem_pkg::AW,
  parameter int DW = dmem_pkg::DW
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          lock1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] data;
  logic          wren;
  logic [DW-1:0] q_dmem;

  // Handshake: a requester holds req with addr/we/wdata until it sees gnt high in the
  // same cycle; the access is accepted on the clock edge that ends a req&gnt cycle.
  // A read accepted in cycle t has rvalid high with rdata in cycle t+1 only.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, q_dmem,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, address_dmem, data, wren
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, q_dmem,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_arb_rr_pick.sv
// Two-input picker: onehot grant from two requests. Round-robin on conflict when
// DMEM_ARB_RR_EN is defined, otherwise port 0 always wins conflicts.
module dmem_arb_rr_pick
  import dmem_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_winner,
  output logic [1:0] gnt
);

`ifndef DMEM_ARB_RR_EN
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
      // The port that did not win last time takes the conflict.
      if (last_winner == PORT_CPU) gnt = 2'b10;
      else                         gnt = 2'b01;
`else
      gnt = 2'b01;
`endif
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter between the processor (port 0) and an auxiliary master (port 1)
// with a port-1 burst lock. Arbitration policy selected by DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output arb_state_e     dbg_state
);

  arb_state_e state_q, state_d;
  logic       last_winner_q, last_winner_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic [1:0] pick_gnt;
  logic       gnt0, gnt1;

  dmem_arb_rr_pick u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_winner (last_winner_q),
    .gnt         (pick_gnt)
  );

  // No grants while reset is asserted, so nothing is accepted in a reset cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (state_q == ARB_LOCK1) begin
        gnt1 = bus.req1;
      end else begin
        gnt0 = pick_gnt[0];
        gnt1 = pick_gnt[1];
      end
    end
  end

  always_comb begin
    bus.address_dmem = '0;
    bus.data         = '0;
    bus.wren         = 1'b0;
    if (gnt0) begin
      bus.address_dmem = bus.addr0;
      bus.data         = bus.wdata0;
      bus.wren         = bus.we0;
    end else if (gnt1) begin
      bus.address_dmem = bus.addr1;
      bus.data         = bus.wdata1;
      bus.wren         = bus.we1;
    end
  end

  // Lock is held exactly while port 1 keeps both req1 and lock1 high on granted cycles.
  always_comb begin
    state_d       = (gnt1 && bus.lock1) ? ARB_LOCK1 : ARB_IDLE;
    last_winner_d = last_winner_q;
    if (gnt0) last_winner_d = PORT_CPU;
    if (gnt1) last_winner_d = PORT_AUX;
    rvalid0_d = gnt0 && !bus.we0;
    rvalid1_d = gnt1 && !bus.we1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      last_winner_q <= PORT_AUX;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = bus.q_dmem;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic, all
// checked against a transaction-level reference model and an expected read-data queue.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_arbiter_if bus ();
  arb_state_e     dbg_state;

  dmem_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Syncram environment: one-cycle read latency, returns old data on read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    bus.q_dmem <= ram[bus.address_dmem];
    if (bus.wren) ram[bus.address_dmem] <= bus.data;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  bit            m_locked;
  int            m_last;
  bit            m_pend0, m_pend1;
  int            m_win;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which port owns dmem this cycle: -1 none, 0 processor, 1 auxiliary.
  function automatic int model_winner();
    if (reset) return -1;
    if (m_locked) return bus.req1 ? 1 : -1;
    if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (bus.req0) return 0;
    if (bus.req1) return 1;
    return -1;
  endfunction

  task automatic sample();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_wren;
    @(negedge clock);
    m_win  = model_winner();
    e_addr = (m_win == 0) ? bus.addr0  : (m_win == 1) ? bus.addr1  : '0;
    e_data = (m_win == 0) ? bus.wdata0 : (m_win == 1) ? bus.wdata1 : '0;
    e_wren = (m_win == 0) ? bus.we0    : (m_win == 1) ? bus.we1    : 1'b0;
    check("gnt0", bus.gnt0, m_win == 0);
    check("gnt1", bus.gnt1, m_win == 1);
    check("address_dmem", bus.address_dmem, e_addr);
    check("data", bus.data, e_data);
    check("wren", bus.wren, e_wren);
    check("rvalid0", bus.rvalid0, m_pend0);
    check("rvalid1", bus.rvalid1, m_pend1);
    check("state", dbg_state, m_locked ? ARB_LOCK1 : ARB_IDLE);
    if (m_pend0 || m_pend1) begin
      check("rdata_queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rdata", bus.rdata, exp_q.pop_front());
    end
  endtask

  task automatic advance();
    if (reset) begin
      m_locked = 0; m_last = 1; m_pend0 = 0; m_pend1 = 0;
      exp_q.delete();
    end else begin
      m_pend0 = (m_win == 0) && !bus.we0;
      m_pend1 = (m_win == 1) && !bus.we1;
      if (m_win == 0) begin
        m_last = 0;
        if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
        else         exp_q.push_back(ref_mem[bus.addr0]);
      end
      if (m_win == 1) begin
        m_last = 1;
        if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
        else         exp_q.push_back(ref_mem[bus.addr1]);
      end
      m_locked = (m_win == 1) && bus.lock1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // ---------------- drivers ----------------
  task automatic drive0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drive1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit l);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] saved [1:3];
    logic [DW-1:0] mem5;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    reset = 1'b1;
    m_locked = 0; m_last = 1; m_pend0 = 0; m_pend1 = 0; m_win = -1;
    drive0(1, 0, 12'd5, '0);
    drive1(0, 0, '0, '0, 0);
    mem5 = ref_mem[5];

    // 1: request held through reset, granted once reset releases
    sample(); check("t1_gnt0_in_reset", bus.gnt0, 0); advance();
    reset = 1'b0;
    sample(); check("t1_gnt0", bus.gnt0, 1); check("t1_addr", bus.address_dmem, 5); advance();
    drive0(0, 0, '0, '0);
    sample(); check("t1_rvalid0", bus.rvalid0, 1); check("t1_rdata", bus.rdata, mem5); advance();

    // 2: conflicting reads from the reset state
    reset = 1'b1; step(); reset = 1'b0;
    drive0(1, 0, 12'd10, '0);
    drive1(1, 0, 12'd20, '0, 0);
    for (int i = 0; i < 4; i++) begin
      sample();
`ifdef DMEM_ARB_RR_EN
      check("t2_gnt0_rr", bus.gnt0, (i % 2) == 0);
      check("t2_gnt1_rr", bus.gnt1, (i % 2) == 1);
`else
      check("t2_gnt0_fixed", bus.gnt0, 1);
      check("t2_gnt1_fixed", bus.gnt1, 0);
`endif
      advance();
    end
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0, 0);
    step();

    // 3: locked burst of port-1 writes blocks port 0, then readback
    drive1(1, 1, 12'd7, 32'hDEADBEEF, 1);
    sample(); check("t3_gnt1_a", bus.gnt1, 1); check("t3_wren_a", bus.wren, 1); advance();
    drive0(1, 0, 12'd7, '0);
    sample(); check("t3_gnt1_b", bus.gnt1, 1); check("t3_gnt0_b", bus.gnt0, 0);
    check("t3_state_lock", dbg_state, ARB_LOCK1); advance();
    bus.lock1 = 1'b0;
    sample(); check("t3_gnt1_c", bus.gnt1, 1); check("t3_gnt0_c", bus.gnt0, 0);
    check("t3_wren_c", bus.wren, 1); advance();
    drive1(0, 0, '0, '0, 0);
    sample(); check("t3_gnt0_after", bus.gnt0, 1); advance();
    drive0(0, 0, '0, '0);
    sample(); check("t3_rvalid0", bus.rvalid0, 1); check("t3_readback", bus.rdata, 32'hDEADBEEF);
    advance();

    // 4: back-to-back port-0 reads
    for (int i = 1; i <= 3; i++) saved[i] = ref_mem[i];
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) drive0(1, 0, AW'(i), '0);
      else        drive0(0, 0, '0, '0);
      sample();
      if (i <= 3) check("t4_gnt0", bus.gnt0, 1);
      if (i >= 2) begin
        check("t4_rvalid0", bus.rvalid0, 1);
        check("t4_rdata", bus.rdata, saved[i-1]);
      end
      advance();
    end

    // 5: reset while locked with a read in flight
    drive1(1, 0, 12'd9, '0, 1);
    step();
    step();
    reset = 1'b1;
    drive0(1, 0, 12'd4, '0);
    sample(); check("t5_rvalid1_before", bus.rvalid1, 1); advance();
    reset = 1'b0;
    sample(); check("t5_rvalid1_dropped", bus.rvalid1, 0);
    check("t5_state_idle", dbg_state, ARB_IDLE); check("t5_gnt0", bus.gnt0, 1); advance();
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0, 0);
    step();

    // 6: quiet bus
    for (int i = 0; i < 10; i++) begin
      sample();
      check("t6_wren", bus.wren, 0);
      check("t6_rvalid0", bus.rvalid0, 0);
      check("t6_rvalid1", bus.rvalid1, 0);
      advance();
    end

    // random traffic; a request that was not granted is held unchanged
    for (int n = 0; n < 600; n++) begin
      if (!(bus.req0 && m_win != 0))
        drive0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
               AW'($urandom_range(0, 31)), $urandom);
      if (!(bus.req1 && m_win != 1))
        drive1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
               AW'($urandom_range(0, 31)), $urandom, 1'b0);
      bus.lock1 = $urandom_range(0, 1) == 1;
      reset = $urandom_range(0, 59) == 0;
      step();
    end

    reset = 1'b0;
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0, 0);
    step();
    step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
